// File: rtl/scanout_pkg.sv
// Shared types and screen geometry for the Hack screen scanout path.
package scanout_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int SCREEN_WORDS  = 8192;
  localparam int SCREEN_ADDR_W = 13;

  localparam rgb565_t DEF_FG_COLOR     = 16'h0000;
  localparam rgb565_t DEF_BG_COLOR     = 16'hFFFF;
  localparam rgb565_t DEF_BORDER_COLOR = 16'hF800;

  function automatic rgb565_t pixel_color(input logic bit_set, input rgb565_t fg, input rgb565_t bg);
    return bit_set ? fg : bg;
  endfunction

endpackage

// File: rtl/scanout_window.sv
// Maps a panel position onto the 512x256 screen window: in-window flag, window
// coordinates, word address and (with SCANOUT_BORDER_EN) the one-pixel frame ring.
module scanout_window
  import scanout_pkg::*;
#(
  parameter int X_OFFSET = 144,
  parameter int Y_OFFSET = 112
) (
  input  logic [9:0]               h_pos,
  input  logic [9:0]               v_pos,
  input  logic                     de,
  output logic                     in_win,
  output logic                     in_ring,
  output logic [8:0]               col,
  output logic [7:0]               row,
  output logic [SCREEN_ADDR_W-1:0] word_addr
);

  localparam logic signed [11:0] X_LO = 12'(X_OFFSET);
  localparam logic signed [11:0] X_HI = 12'(X_OFFSET + SCREEN_W - 1);
  localparam logic signed [11:0] Y_LO = 12'(Y_OFFSET);
  localparam logic signed [11:0] Y_HI = 12'(Y_OFFSET + SCREEN_H - 1);

  logic signed [11:0] h_s;
  logic signed [11:0] v_s;
  logic               in_x;
  logic               in_y;

  // Signed compares keep the ring bounds correct even for a zero offset.
  assign h_s  = $signed({2'b00, h_pos});
  assign v_s  = $signed({2'b00, v_pos});
  assign in_x = (h_s >= X_LO) && (h_s <= X_HI);
  assign in_y = (v_s >= Y_LO) && (v_s <= Y_HI);

  assign in_win    = de && in_x && in_y;
  assign col       = 9'(h_pos - 10'(X_OFFSET));
  assign row       = 8'(v_pos - 10'(Y_OFFSET));
  assign word_addr = {row, col[8:4]};

`ifdef SCANOUT_BORDER_EN
  localparam logic signed [11:0] XR_LO = 12'(X_OFFSET - 1);
  localparam logic signed [11:0] XR_HI = 12'(X_OFFSET + SCREEN_W);
  localparam logic signed [11:0] YR_LO = 12'(Y_OFFSET - 1);
  localparam logic signed [11:0] YR_HI = 12'(Y_OFFSET + SCREEN_H);

  logic in_rx;
  logic in_ry;

  assign in_rx   = (h_s >= XR_LO) && (h_s <= XR_HI);
  assign in_ry   = (v_s >= YR_LO) && (v_s <= YR_HI);
  assign in_ring = de && in_rx && in_ry && !(in_x && in_y);
`else
  assign in_ring = 1'b0;
`endif

endmodule

// File: rtl/screen_scanout.sv
// Two-stage pixel fetch from Hack screen memory to RGB565 with a one-word cache.
// Optional frame ring around the window is enabled by SCANOUT_BORDER_EN.
module screen_scanout
  import scanout_pkg::*;
#(
  parameter int      X_OFFSET     = 144,
  parameter int      Y_OFFSET     = 112,
  parameter rgb565_t FG_COLOR     = DEF_FG_COLOR,
  parameter rgb565_t BG_COLOR     = DEF_BG_COLOR,
  parameter rgb565_t BORDER_COLOR = DEF_BORDER_COLOR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               h_pos,
  input  logic [9:0]               v_pos,
  input  logic                     de,
  input  logic                     vs,
  output logic                     rd_en,
  output logic [SCREEN_ADDR_W-1:0] rd_addr,
  input  logic [15:0]              rd_data,
  output logic [15:0]              pixel_rgb,
  output logic                     pixel_de
);

  logic                     in_win;
  logic                     in_ring;
  logic [8:0]               col;
  logic [7:0]               row;
  logic [SCREEN_ADDR_W-1:0] word_addr;

  logic [SCREEN_ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic                     cache_valid_q, cache_valid_d;
  logic [15:0]              cache_word_q, cache_word_d;

  logic                     s1_de_q;
  logic                     s1_in_win_q;
  logic                     s1_ring_q;
  logic [3:0]               s1_bit_q;
  logic                     s1_fetched_q;

  rgb565_t                  pixel_rgb_q, pixel_rgb_d;
  logic                     pixel_de_q;
  logic [15:0]              word_s;
  logic                     cache_hit_s;

  scanout_window #(
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET)
  ) u_window (
    .h_pos     (h_pos),
    .v_pos     (v_pos),
    .de        (de),
    .in_win    (in_win),
    .in_ring   (in_ring),
    .col       (col),
    .row       (row),
    .word_addr (word_addr)
  );

  // Stage 0: fetch on a cache miss; vs drops validity even after a same-cycle fetch.
  always_comb begin
    cache_hit_s   = cache_valid_q && (word_addr == cache_addr_q);
    rd_en         = reset && in_win && !cache_hit_s;
    rd_addr       = rd_en ? word_addr : {SCREEN_ADDR_W{1'b0}};
    cache_addr_d  = rd_en ? word_addr : cache_addr_q;
    cache_valid_d = vs ? 1'b0 : (rd_en ? 1'b1 : cache_valid_q);
  end

  // Stage 1: pick the fresh memory word or the cached one and colour the pixel.
  always_comb begin
    word_s       = s1_fetched_q ? rd_data : cache_word_q;
    cache_word_d = word_s;
    pixel_rgb_d  = 16'h0000;
    if (!s1_de_q) begin
      pixel_rgb_d = 16'h0000;
    end else if (s1_in_win_q) begin
      pixel_rgb_d = pixel_color(word_s[s1_bit_q], FG_COLOR, BG_COLOR);
    end else if (s1_ring_q) begin
      pixel_rgb_d = BORDER_COLOR;
    end else begin
      pixel_rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_addr_q  <= {SCREEN_ADDR_W{1'b0}};
      cache_valid_q <= 1'b0;
      cache_word_q  <= 16'h0000;
      s1_de_q       <= 1'b0;
      s1_in_win_q   <= 1'b0;
      s1_ring_q     <= 1'b0;
      s1_bit_q      <= 4'h0;
      s1_fetched_q  <= 1'b0;
      pixel_rgb_q   <= 16'h0000;
      pixel_de_q    <= 1'b0;
    end else begin
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_word_q  <= cache_word_d;
      s1_de_q       <= de;
      s1_in_win_q   <= in_win;
      s1_ring_q     <= in_ring;
      s1_bit_q      <= col[3:0];
      s1_fetched_q  <= rd_en;
      pixel_rgb_q   <= pixel_rgb_d;
      pixel_de_q    <= s1_de_q;
    end
  end

  assign pixel_rgb = pixel_rgb_q;
  assign pixel_de  = pixel_de_q;

  // Row bits above the window height never matter; the address carries them.
  logic unused_row_s;
  assign unused_row_s = ^row;

endmodule

// File: tb/tb_screen_scanout.sv
// Scoreboard bench for screen_scanout: expected pixels queued at drive time, popped 2 clocks later.
module tb_screen_scanout;

  localparam int XO = 144;
  localparam int YO = 112;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_pos;
  logic [9:0]  v_pos;
  logic        de;
  logic        vs;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;
  logic [15:0] pixel_rgb;
  logic        pixel_de;

  logic [15:0] mem [8192];

  typedef struct {
    logic        de;
    logic [15:0] rgb;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int reads = 0;
  int last_addr = 0;
  int r0;
  bit mvalid = 1'b0;
  int maddr = 0;

  screen_scanout dut (
    .clk       (clk),
    .reset     (reset),
    .h_pos     (h_pos),
    .v_pos     (v_pos),
    .de        (de),
    .vs        (vs),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pixel_rgb (pixel_rgb),
    .pixel_de  (pixel_de)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic logic win(int h, int v, logic d);
    return d && (h >= XO) && (h <= XO + 511) && (v >= YO) && (v <= YO + 255);
  endfunction

  function automatic int waddr(int h, int v);
    return (v - YO) * 32 + (h - XO) / 16;
  endfunction

  function automatic logic [15:0] exp_pix(int h, int v, logic d);
    logic [15:0] w;
    if (!d) return 16'h0000;
    if (win(h, v, d)) begin
      w = mem[waddr(h, v)];
      return w[(h - XO) % 16] ? 16'h0000 : 16'hFFFF;
    end
`ifdef SCANOUT_BORDER_EN
    if ((h >= XO - 1) && (h <= XO + 512) && (v >= YO - 1) && (v <= YO + 256)) return 16'hF800;
`endif
    return 16'hFFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int h, input int v, input logic d, input logic vsync);
    exp_t e;
    logic exp_rd;
    int   a;
    @(negedge clk);
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      check("pixel_de", 32'(pixel_de), 32'(e.de));
      check("pixel_rgb", 32'(pixel_rgb), 32'(e.rgb));
    end
    h_pos = h[9:0];
    v_pos = v[9:0];
    de    = d;
    vs    = vsync;
    e.de  = d;
    e.rgb = exp_pix(h, v, d);
    sbq.push_back(e);
    #1;
    a      = win(h, v, d) ? waddr(h, v) : 0;
    exp_rd = win(h, v, d) && (!mvalid || (a != maddr));
    check("rd_en", 32'(rd_en), 32'(exp_rd));
    check("rd_addr", 32'(rd_addr), 32'(exp_rd ? a : 0));
    if (rd_en) begin
      reads++;
      last_addr = int'(rd_addr);
    end
    if (exp_rd) begin
      mvalid = 1'b1;
      maddr  = a;
    end
    if (vsync) mvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    rd_data = 16'h0000;
    reset = 1'b0;
    h_pos = 10'd144;
    v_pos = 10'd112;
    de    = 1'b1;
    vs    = 1'b0;
    #22;
    check("reset_rgb", 32'(pixel_rgb), 32'h0);
    check("reset_de", 32'(pixel_de), 32'h0);
    check("reset_rd_en", 32'(rd_en), 32'h0);
    @(negedge clk);
    de = 1'b0;
    #2 reset = 1'b1;

    // Pixel decode: only bit 0 set
    mem[0] = 16'h0001;
    r0 = reads;
    for (int h = 144; h <= 159; h++) step(h, 112, 1'b1, 1'b0);
    check("decode_reads", 32'(reads - r0), 32'd1);
    check("decode_addr", 32'(last_addr), 32'd0);
    step(0, 0, 1'b0, 1'b0);

    // Bit order: only bit 15 set, refetch forced by vs
    mem[0] = 16'h8000;
    step(0, 0, 1'b0, 1'b1);
    r0 = reads;
    for (int h = 144; h <= 159; h++) step(h, 112, 1'b1, 1'b0);
    check("bitorder_reads", 32'(reads - r0), 32'd1);

    // Full line fetch
    step(0, 0, 1'b0, 1'b1);
    r0 = reads;
    for (int h = 0; h <= 799; h++) step(h, 112, 1'b1, 1'b0);
    check("line_reads", 32'(reads - r0), 32'd32);
    check("line_last_addr", 32'(last_addr), 32'd31);

    // Last word of the screen and first pixel past the window
    mem[8191] = 16'hFFFF;
    r0 = reads;
    for (int h = 640; h <= 656; h++) step(h, 367, 1'b1, 1'b0);
    check("lastword_reads", 32'(reads - r0), 32'd1);
    check("lastword_addr", 32'(last_addr), 32'd8191);

    // Jumps and frame invalidation
    mem[2816] = 16'h0040;
    mem[2825] = 16'h1000;
    r0 = reads;
    step(150, 200, 1'b1, 1'b0);
    check("jump_a_addr", 32'(last_addr), 32'd2816);
    step(300, 200, 1'b1, 1'b0);
    check("jump_b_addr", 32'(last_addr), 32'd2825);
    step(0, 0, 1'b0, 1'b1);
    step(150, 200, 1'b1, 1'b0);
    check("jump_c_addr", 32'(last_addr), 32'd2816);
    check("jump_reads", 32'(reads - r0), 32'd3);

    // Reset mid-line
    mem[256] = 16'h5555;
    mem[257] = 16'hA5A5;
    for (int h = 144; h <= 170; h++) step(h, 120, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midreset_rgb", 32'(pixel_rgb), 32'h0);
    check("midreset_de", 32'(pixel_de), 32'h0);
    check("midreset_rd_en", 32'(rd_en), 32'h0);
    sbq.delete();
    mvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    r0 = reads;
    step(171, 120, 1'b1, 1'b0);
    check("postreset_refetch", 32'(reads - r0), 32'd1);
    check("postreset_addr", 32'(last_addr), 32'd257);
    for (int h = 172; h <= 180; h++) step(h, 120, 1'b1, 1'b0);

    // Ring positions (BORDER_COLOR only with the border build)
    r0 = reads;
    step(143, 200, 1'b1, 1'b0);
    step(656, 300, 1'b1, 1'b0);
    step(400, 111, 1'b1, 1'b0);
    step(143, 100, 1'b1, 1'b0);
    check("ring_no_reads", 32'(reads - r0), 32'd0);

    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/screen_scanout.md
Name: screen_scanout

Overview:
- Pixel-fetch stage directly upstream of the RGB LCD pixel sink.
- Converts the LCD timing generator's current position (h_pos, v_pos, de) into RGB565 pixel data.
- Reads the Hack 512x256 1bpp screen memory (8192 x 16-bit words) through a synchronous read port and places the image in a window on the 800x480 panel.
- Caches one screen word so memory is read once per 16 pixels.

Parameters:
- X_OFFSET, 144, first panel column of the screen window.
- Y_OFFSET, 112, first panel row of the screen window.
- FG_COLOR, 16'h0000, RGB565 for a set bit (Hack "black").
- BG_COLOR, 16'hFFFF, RGB565 for a clear bit and for outside the window.
- BORDER_COLOR, 16'hF800, RGB565 for the frame ring (only with SCANOUT_BORDER_EN).

Ports:
- clk  in  1  pixel clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- h_pos  in  10  current panel column from the timing generator.
- v_pos  in  10  current panel row.
- de  in  1  data enable; position is visible when high.
- vs  in  1  vertical sync; high for one or more cycles per frame.
- rd_en  out  1  screen memory read strobe (combinational).
- rd_addr  out  13  screen word address (combinational).
- rd_data  in  16  screen word; valid exactly 1 cycle after rd_en.
- pixel_rgb  out  16  RGB565 pixel (registered).
- pixel_de  out  1  de delayed to align with pixel_rgb.

Behaviour:
- Reset (asynchronous, active-low): pixel_rgb=0, pixel_de=0, cache_valid=0, all pipeline valid bits 0. rd_en is forced 0 while reset is low.
- Window condition: in_win = de & h_pos in [X_OFFSET, X_OFFSET+511] & v_pos in [Y_OFFSET, Y_OFFSET+255].
- Window coordinates: col = h_pos-X_OFFSET (9b), row = v_pos-Y_OFFSET (8b). Subtractions are unsigned; in_win gates every use of col and row.
- Address: word address = {row, col[8:4]} = row*32 + col/16. Range 0..8191; no wrap is possible inside the window.
- Bit order: pixel bit = col[3:0]. Bit 0 is the leftmost pixel of the word (Hack convention). Bit 1 selects FG_COLOR, bit 0 selects BG_COLOR.
- Stage 0, cycle t:
  - rd_en = in_win & (!cache_valid | word_addr != cache_addr).
  - rd_addr = word_addr when rd_en is high, otherwise 0.
  - On rd_en: cache_addr <= word_addr, cache_valid <= 1.
- Stage 1, cycle t+1:
  - Registered s1_de, s1_in_win, s1_bit, s1_fetched.
  - word = s1_fetched ? rd_data : cache_word.
  - On s1_fetched: cache_word <= rd_data.
- Output, registered at end of t+1 (visible at t+2):
  - pixel_rgb = s1_in_win ? color(word[s1_bit]) : BG_COLOR.
  - pixel_de = s1_de.
  - pixel_rgb = 0 when s1_de = 0.
- Latency: exactly 2 clk from position inputs to pixel_rgb/pixel_de. The timing generator is responsible for compensating the pipeline delay.
- Fetch rate: contiguous scanning issues exactly 32 reads per window line, at col = 0, 16, ..., 496.
- Non-contiguous positions (jumps): the address compare forces a refetch; no stale word is ever used for a different address.
- vs high: cache_valid <= 0, so the first window pixel of every frame fetches.
- Simultaneous vs and in_win: the fetch still occurs and the cache is invalidated after it. This is harmless.
- Writes to screen memory during a line: a cached word may lag by up to 15 pixels. This is accepted.
- de low: no reads are issued, and cache state is held.
- Reset mid-line: outputs clear immediately. The first in-window pixel after release refetches.

Optional Feature:
- Macro: SCANOUT_BORDER_EN.
- Defined: panel pixels within the one-pixel ring just outside the window output BORDER_COLOR instead of BG_COLOR. The ring covers columns X_OFFSET-1 and X_OFFSET+512 over rows Y_OFFSET-1..Y_OFFSET+256, plus rows Y_OFFSET-1 and Y_OFFSET+256 over the same column span. No memory reads are issued for ring pixels.
- Undefined: the ring logic is absent and all out-of-window pixels are BG_COLOR.

Decomposition:
- Package scanout_pkg:
  - typedef rgb565_t (16b).
  - SCREEN_W=512, SCREEN_H=256, WORDS_PER_ROW=32, SCREEN_WORDS=8192, SCREEN_ADDR_W=13.
  - Default colour constants.
- Sub-module scanout_window: combinational in_win, ring flag, col/row and word address from h_pos/v_pos. Shared with future cursor or overlay stages.

Test Plan:
- Pixel decode: word[0]=16'h0001, all others 0. Scan v=112, h=144..159 with de=1 → pixel_rgb at t+2 is 16'h0000 for h=144 and 16'hFFFF for h=145..159. rd_en pulses once with rd_addr=0.
- Bit order: word[0]=16'h8000 → only h=159 yields FG_COLOR.
- Line fetch: full scan of v=112, h=0..799 → exactly 32 rd_en pulses with addresses 0..31. pixel_de mirrors de delayed by 2.
- Last word: word[8191]=16'hFFFF. Scan v=367, h=640..655 → rd_addr=8191 and FG_COLOR for all 16 pixels. h=656 → BG_COLOR with no read.
- Jump and frame: present h=150 then h=300 on v=200, then pulse vs and revisit h=150 → each step issues a fresh read (addresses 2816, 2825, 2816).
- Reset mid-line: reset low at v=120, h=170 → pixel_rgb=0 and pixel_de=0 asynchronously. After release, the next in-window pixel refetches. With SCANOUT_BORDER_EN, (h=143, v=200) → 16'hF800.
